// File: rtl/dm_hart_ctrl_if.sv
// Bundle between the debug module register file / core debug FSM (master)
// and the hart controller (slave). Names keep the controller's point of view.
interface dm_hart_ctrl_if;
  logic        dmactive_i;
  logic        haltreq_i;
  logic        resumereq_i;
  logic        cmd_valid_i;
  logic [31:0] cmd_i;
  logic        data0_wr_i;
  logic [31:0] data0_wdata_i;
  logic [2:0]  cmderr_clr_i;
  logic        core_halted_i;
  logic        core_running_i;
  logic        core_resumeack_i;
  logic [31:0] dbg_ar_di_i;

  logic        dbg_haltreq_o;
  logic        dbg_resumereq_o;
  logic        dbg_ar_en_o;
  logic        dbg_ar_wr_o;
  logic [15:0] dbg_ar_ad_o;
  logic [31:0] dbg_ar_do_o;
  logic [31:0] data0_o;
  logic        busy_o;
  logic [2:0]  cmderr_o;
  logic        resumeack_o;

  modport slave (
    input  dmactive_i, haltreq_i, resumereq_i, cmd_valid_i, cmd_i,
           data0_wr_i, data0_wdata_i, cmderr_clr_i, core_halted_i,
           core_running_i, core_resumeack_i, dbg_ar_di_i,
    output dbg_haltreq_o, dbg_resumereq_o, dbg_ar_en_o, dbg_ar_wr_o,
           dbg_ar_ad_o, dbg_ar_do_o, data0_o, busy_o, cmderr_o, resumeack_o
  );

  modport master (
    output dmactive_i, haltreq_i, resumereq_i, cmd_valid_i, cmd_i,
           data0_wr_i, data0_wdata_i, cmderr_clr_i, core_halted_i,
           core_running_i, core_resumeack_i, dbg_ar_di_i,
    input  dbg_haltreq_o, dbg_resumereq_o, dbg_ar_en_o, dbg_ar_wr_o,
           dbg_ar_ad_o, dbg_ar_do_o, data0_o, busy_o, cmderr_o, resumeack_o
  );
endinterface

// File: rtl/dm_hart_ctrl.sv
// Debug-module hart controller: halt/resume handshake with the core and
// single-beat 32-bit Access Register commands through data0.
module dm_hart_ctrl #(
  parameter logic [15:0] GPR_LAST = 16'h101f
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  dm_hart_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} r_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ACCESS, C_RDATA, C_DONE} c_state_t;

  r_state_t    r_state;
  c_state_t    c_state;
  logic        haltreq_q;
  logic        resumereq_q;
  logic        resumeack;
  logic        ar_en;
  logic        ar_wr;
  logic [15:0] ar_ad;
  logic [31:0] data0;
  logic [2:0]  cmderr;

  logic        busy;
  logic [2:0]  cmderr_masked;
  logic [2:0]  cmd_err;
  logic        cmd_accept;
  logic        resume_accept;
  logic        unused_cmd_bit;

  assign busy           = (c_state != C_IDLE);
  assign unused_cmd_bit = bus.cmd_i[23];

  // The W1C clear is applied first so that a same-cycle error lands in a clean field.
  always_comb begin
    cmderr_masked = cmderr & ~bus.cmderr_clr_i;
    cmd_err       = 3'd0;
    cmd_accept    = 1'b0;
    if (bus.cmd_valid_i && (cmderr_masked == 3'd0)) begin
      if (busy)
        cmd_err = 3'd1;
      else if ((bus.cmd_i[31:24] != 8'd0) || (bus.cmd_i[22:20] != 3'd2) ||
               bus.cmd_i[19] || bus.cmd_i[18])
        cmd_err = 3'd2;
      else if (!bus.core_halted_i || (r_state != R_IDLE))
        cmd_err = 3'd4;
      else if (bus.cmd_i[17] && (bus.cmd_i[15:0] > GPR_LAST))
        cmd_err = 3'd3;
      else
        cmd_accept = 1'b1;
    end
    resume_accept = bus.resumereq_i && (r_state == R_IDLE) && bus.core_halted_i &&
                    !bus.haltreq_i && !busy && !cmd_accept;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni || !bus.dmactive_i) begin
      r_state     <= R_IDLE;
      c_state     <= C_IDLE;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      resumeack   <= 1'b0;
      ar_en       <= 1'b0;
      ar_wr       <= 1'b0;
      ar_ad       <= 16'd0;
      data0       <= 32'd0;
      cmderr      <= 3'd0;
    end else begin
      haltreq_q <= bus.haltreq_i;

      if (cmd_err != 3'd0)
        cmderr <= cmd_err;
      else if (bus.data0_wr_i && busy && (cmderr_masked == 3'd0))
        cmderr <= 3'd1;
      else
        cmderr <= cmderr_masked;

      if (c_state == C_RDATA)
        data0 <= bus.dbg_ar_di_i;
      else if (bus.data0_wr_i && !busy)
        data0 <= bus.data0_wdata_i;

      ar_en <= 1'b0;
      ar_wr <= 1'b0;
      ar_ad <= 16'd0;
      case (c_state)
        C_IDLE: begin
          if (cmd_accept) begin
            if (bus.cmd_i[17]) begin
              c_state <= C_ACCESS;
              ar_en   <= 1'b1;
              ar_wr   <= bus.cmd_i[16];
              ar_ad   <= bus.cmd_i[15:0];
            end else begin
              c_state <= C_DONE;
            end
          end
        end
        C_ACCESS: c_state <= ar_wr ? C_IDLE : C_RDATA;
        C_RDATA:  c_state <= C_IDLE;
        C_DONE:   c_state <= C_IDLE;
        default:  c_state <= C_IDLE;
      endcase

      // resumeack stays set from the end of one handshake until the next accepted request.
      case (r_state)
        R_IDLE: begin
          if (resume_accept) begin
            r_state     <= R_REQ;
            resumereq_q <= 1'b1;
            resumeack   <= 1'b0;
          end
        end
        R_REQ: begin
          if (bus.core_resumeack_i) begin
            r_state     <= R_WAIT;
            resumereq_q <= 1'b0;
          end
        end
        R_WAIT: begin
          if (bus.core_running_i) begin
            r_state   <= R_IDLE;
            resumeack <= 1'b1;
          end
        end
        default: begin
          r_state     <= R_IDLE;
          resumereq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dbg_haltreq_o   = haltreq_q;
  assign bus.dbg_resumereq_o = resumereq_q;
  assign bus.dbg_ar_en_o     = ar_en;
  assign bus.dbg_ar_wr_o     = ar_wr;
  assign bus.dbg_ar_ad_o     = ar_ad;
  assign bus.dbg_ar_do_o     = ar_en ? data0 : 32'd0;
  assign bus.data0_o         = data0;
  assign bus.busy_o          = busy;
  assign bus.cmderr_o        = cmderr;
  assign bus.resumeack_o     = resumeack;

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Scoreboard bench for dm_hart_ctrl: directed cases plus randomized command
// traffic checked against an operation-level model of data0/cmderr/accesses.
module tb_dm_hart_ctrl;

  localparam logic [15:0] GPR_LAST = 16'h101f;

  typedef struct packed {
    logic        wr;
    logic [15:0] ad;
    logic [31:0] dat;
  } acc_t;

  typedef struct packed {
    logic [31:0] data0;
    logic [2:0]  cmderr;
  } done_t;

  logic clk_i = 1'b0;
  logic reset_ni;
  always #5 clk_i = ~clk_i;

  dm_hart_ctrl_if bus ();

  dm_hart_ctrl #(.GPR_LAST(GPR_LAST)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  acc_t  acc_q[$];
  done_t done_q[$];
  acc_t  mon_acc;
  done_t mon_done;
  logic  busy_prev = 1'b0;

  logic [31:0] m_data0;
  logic [2:0]  m_cmderr;
  logic        m_halted;
  logic        m_resumeack;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every access strobe and every end of busy is matched against the queues.
  always @(negedge clk_i) begin
    if (bus.dbg_ar_en_o === 1'b1) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_access actual=en required=none");
      end else begin
        mon_acc = acc_q.pop_front();
        checkOutput("ar_wr", 32'(bus.dbg_ar_wr_o), 32'(mon_acc.wr));
        checkOutput("ar_ad", 32'(bus.dbg_ar_ad_o), 32'(mon_acc.ad));
        checkOutput("ar_do", bus.dbg_ar_do_o, mon_acc.dat);
      end
    end else begin
      checkOutput("ar_idle_zero",
                  32'(|{bus.dbg_ar_wr_o, bus.dbg_ar_ad_o, bus.dbg_ar_do_o}), 32'd0);
    end
    if (busy_prev && !bus.busy_o) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done actual=busy_fall required=none");
      end else begin
        mon_done = done_q.pop_front();
        checkOutput("done_data0", bus.data0_o, mon_done.data0);
        checkOutput("done_cmderr", 32'(bus.cmderr_o), 32'(mon_done.cmderr));
      end
    end
    busy_prev = bus.busy_o;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Returns {accepted, error code} for a command issued while idle.
  function automatic logic [3:0] model_decode(input logic [31:0] c);
    if (m_cmderr != 3'd0) return 4'b0000;
    if ((c[31:24] != 8'd0) || (c[22:20] != 3'd2) || c[19] || c[18]) return {1'b0, 3'd2};
    if (!m_halted) return {1'b0, 3'd4};
    if (c[17] && (c[15:0] > GPR_LAST)) return {1'b0, 3'd3};
    return {1'b1, 3'd0};
  endfunction

  function automatic logic [31:0] rand_cmd();
    logic [7:0]  ctype;
    logic [2:0]  size;
    logic [15:0] regno;
    ctype = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    size  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2;
    case ($urandom_range(0, 2))
      0:       regno = 16'($urandom_range(0, 16'h0fff));
      1:       regno = 16'($urandom_range(16'h1000, GPR_LAST));
      default: regno = 16'($urandom_range(GPR_LAST + 1, 16'hffff));
    endcase
    return {ctype, 1'($urandom), size, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 1'($urandom), regno};
  endfunction

  // collide: 0 none, 1 command write in cycle N+1, 2 data0 write in cycle N+1
  task automatic applyStimulus(input logic [31:0] c, input int collide);
    logic [3:0] dec;
    int exp_busy;
    int cyc;
    logic timed_out;
    dec = model_decode(c);
    exp_busy = 0;
    if (dec[3]) begin
      if (c[17]) begin
        acc_q.push_back('{wr: c[16], ad: c[15:0], dat: m_data0});
        if (!c[16]) m_data0 = bus.dbg_ar_di_i;
        exp_busy = c[16] ? 1 : 2;
      end else begin
        exp_busy = 1;
      end
      if (collide != 0 && m_cmderr == 3'd0) m_cmderr = 3'd1;
      done_q.push_back('{data0: m_data0, cmderr: m_cmderr});
    end else begin
      if (dec[2:0] != 3'd0) m_cmderr = dec[2:0];
      collide = 0;
    end

    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = c;
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    if (collide == 1) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_i       = $urandom;
    end else if (collide == 2) begin
      bus.data0_wr_i    = 1'b1;
      bus.data0_wdata_i = $urandom;
    end
    cyc = 0;
    @(negedge clk_i);
    if (bus.busy_o) cyc++;
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    bus.data0_wr_i  = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (!bus.busy_o) begin
        timed_out = 1'b0;
        break;
      end
      cyc++;
    end
    if (timed_out) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy_timeout actual=busy required=idle");
    end
    checkOutput("busy_cycles", 32'(cyc), 32'(exp_busy));
    checkOutput("cmderr", 32'(bus.cmderr_o), 32'(m_cmderr));
    checkOutput("data0", bus.data0_o, m_data0);
  endtask

  task automatic write_data0(input logic [31:0] v);
    @(posedge clk_i); #1;
    bus.data0_wr_i    = 1'b1;
    bus.data0_wdata_i = v;
    @(posedge clk_i); #1;
    bus.data0_wr_i = 1'b0;
    m_data0 = v;
    @(negedge clk_i);
    checkOutput("data0_write", bus.data0_o, m_data0);
  endtask

  task automatic clear_cmderr(input logic [2:0] mask);
    @(posedge clk_i); #1;
    bus.cmderr_clr_i = mask;
    @(posedge clk_i); #1;
    bus.cmderr_clr_i = 3'd0;
    m_cmderr = m_cmderr & ~mask;
    @(negedge clk_i);
    checkOutput("cmderr_clear", 32'(bus.cmderr_o), 32'(m_cmderr));
  endtask

  task automatic set_core(input logic halted);
    m_halted = halted;
    bus.core_halted_i  = halted;
    bus.core_running_i = !halted;
  endtask

  task automatic do_resume(input logic accept);
    @(posedge clk_i); #1;
    bus.resumereq_i = 1'b1;
    @(posedge clk_i); #1;
    bus.resumereq_i = 1'b0;
    @(negedge clk_i);
    checkOutput("resumereq_start", 32'(bus.dbg_resumereq_o), 32'(accept));
    if (!accept) begin
      checkOutput("resumeack_hold", 32'(bus.resumeack_o), 32'(m_resumeack));
      return;
    end
    m_resumeack = 1'b0;
    checkOutput("resumeack_cleared", 32'(bus.resumeack_o), 32'(m_resumeack));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("resumereq_held", 32'(bus.dbg_resumereq_o), 32'd1);
    @(posedge clk_i); #1;
    bus.core_resumeack_i = 1'b1;
    @(posedge clk_i); #1;
    bus.core_resumeack_i = 1'b0;
    set_core(1'b0);
    @(negedge clk_i);
    checkOutput("resumereq_dropped", 32'(bus.dbg_resumereq_o), 32'd0);
    checkOutput("resumeack_wait", 32'(bus.resumeack_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    m_resumeack = 1'b1;
    checkOutput("resumeack_set", 32'(bus.resumeack_o), 32'(m_resumeack));
    @(posedge clk_i); #1;
    set_core(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_haltreq"}, 32'(bus.dbg_haltreq_o), 32'd0);
    checkOutput({tag, "_resumereq"}, 32'(bus.dbg_resumereq_o), 32'd0);
    checkOutput({tag, "_ar_en"}, 32'(bus.dbg_ar_en_o), 32'd0);
    checkOutput({tag, "_ar_wr"}, 32'(bus.dbg_ar_wr_o), 32'd0);
    checkOutput({tag, "_ar_ad"}, 32'(bus.dbg_ar_ad_o), 32'd0);
    checkOutput({tag, "_ar_do"}, bus.dbg_ar_do_o, 32'd0);
    checkOutput({tag, "_data0"}, bus.data0_o, 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    checkOutput({tag, "_cmderr"}, 32'(bus.cmderr_o), 32'd0);
    checkOutput({tag, "_resumeack"}, 32'(bus.resumeack_o), 32'd0);
  endtask

  initial begin
    logic [31:0] c;
    logic [2:0]  mask;
    int op;
    int collide;

    reset_ni             = 1'b0;
    bus.dmactive_i       = 1'b1;
    bus.haltreq_i        = 1'b0;
    bus.resumereq_i      = 1'b0;
    bus.cmd_valid_i      = 1'b0;
    bus.cmd_i            = 32'd0;
    bus.data0_wr_i       = 1'b0;
    bus.data0_wdata_i    = 32'd0;
    bus.cmderr_clr_i     = 3'd0;
    bus.core_resumeack_i = 1'b0;
    bus.dbg_ar_di_i      = 32'd0;
    set_core(1'b1);
    m_data0     = 32'd0;
    m_cmderr    = 3'd0;
    m_resumeack = 1'b0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    reset_ni = 1'b1;

    // Halt request is a one-cycle registered copy.
    @(posedge clk_i); #1;
    bus.haltreq_i = 1'b1;
    @(negedge clk_i);
    checkOutput("haltreq_latency", 32'(bus.dbg_haltreq_o), 32'd0);
    @(negedge clk_i);
    checkOutput("haltreq_follow", 32'(bus.dbg_haltreq_o), 32'd1);
    @(posedge clk_i); #1;
    bus.haltreq_i = 1'b0;
    @(posedge clk_i);

    write_data0(32'hDEADBEEF);
    applyStimulus(32'h0023_07B1, 0);
    bus.dbg_ar_di_i = 32'h1234_5678;
    applyStimulus(32'h0022_1005, 0);

    applyStimulus(32'h0033_1005, 0);
    applyStimulus(32'h0023_1000, 0);
    clear_cmderr(3'b111);
    set_core(1'b0);
    applyStimulus(32'h0022_1005, 0);
    clear_cmderr(3'b111);
    set_core(1'b1);
    applyStimulus(32'h0022_1020, 0);
    clear_cmderr(3'b111);
    applyStimulus(32'h0020_0300, 0);

    bus.dbg_ar_di_i = 32'hA5A5_0F0F;
    applyStimulus(32'h0022_1001, 1);
    clear_cmderr(3'b111);
    bus.dbg_ar_di_i = 32'h0BAD_F00D;
    applyStimulus(32'h0022_1002, 2);
    clear_cmderr(3'b111);

    do_resume(1'b1);
    bus.haltreq_i = 1'b1;
    do_resume(1'b0);
    bus.haltreq_i = 1'b0;
    do_resume(1'b1);

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op < 5) begin
        c = rand_cmd();
        bus.dbg_ar_di_i = $urandom;
        collide = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        applyStimulus(c, collide);
      end else if (op < 7) begin
        write_data0($urandom);
      end else if (op < 9) begin
        mask = 3'($urandom_range(0, 7));
        clear_cmderr(mask);
      end else begin
        @(posedge clk_i); #1;
        set_core(!m_halted);
      end
    end

    // Reset during C_ACCESS of a write.
    set_core(1'b1);
    clear_cmderr(3'b111);
    write_data0($urandom | 32'd1);
    acc_q.push_back('{wr: 1'b1, ad: 16'h1003, dat: m_data0});
    done_q.push_back('{data0: 32'd0, cmderr: 3'd0});
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = 32'h0023_1003;
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    m_data0 = 32'd0; m_cmderr = 3'd0; m_resumeack = 1'b0;
    check_all_zero("rst_access");
    @(posedge clk_i); #1;
    reset_ni = 1'b1;

    // dmactive drop during C_RDATA discards the read.
    write_data0($urandom | 32'd1);
    bus.dbg_ar_di_i = $urandom | 32'd1;
    acc_q.push_back('{wr: 1'b0, ad: 16'h0010, dat: m_data0});
    done_q.push_back('{data0: 32'd0, cmderr: 3'd0});
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = 32'h0022_0010;
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    bus.dmactive_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    m_data0 = 32'd0;
    check_all_zero("dmactive_rdata");
    @(posedge clk_i); #1;
    bus.dmactive_i = 1'b1;

    repeat (3) @(negedge clk_i);
    checkOutput("acc_q_drained", 32'(acc_q.size()), 32'd0);
    checkOutput("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
